hack_pc_sequencer: RTL and testbench
====================================

Name: hack_pc_sequencer

Overview:
Program-counter and clock-step sequencer that sits directly upstream of the Hack control decoder on the Basys3 board. It holds the 15-bit PC that addresses instruction ROM. It advances the PC one instruction at a time, either on a debounced step button or free-running at a divided rate. On each advance it takes the decoder's jump decision (load_pc) and the A-register jump target.

Parameters:
PC_W, 15, PC width (Hack ROM address space).
DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must be stable before it is accepted (10 ms at 100 MHz).
RUN_DIV, 50000000, cycles between advances in RUN mode (2 Hz at 100 MHz); minimum 2.

Ports:
clk  input  1  100 MHz board clock
rst_n  input  1  asynchronous active-low reset
btn_step  input  1  raw step button, asynchronous to clk
btn_run  input  1  raw run/pause toggle button, asynchronous to clk
load_pc  input  1  jump-taken from control decoder, combinational off current instruction
a_reg  input  16  current A register value (jump target)
bp_addr  input  PC_W  breakpoint address (used only with BREAKPOINT_EN)
pc  output  PC_W  current ROM address
step_pulse  output  1  one-cycle commit strobe; A/D/M writes and PC update occur on the edge that ends it
running  output  1  1 while in RUN state
bp_hit  output  1  sticky breakpoint flag

Behaviour:
- Reset (rst_n=0, asynchronous): pc=0, step_pulse=0, running=0, bp_hit=0, FSM=PAUSE, debounce counters=0, debounced levels=0, divider=0.
- Button path, per button:
  - 2-flop synchronizer.
  - Counter reloads to 0 on any change of the synchronized level; debounced level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - A rising edge of the debounced level produces a one-cycle internal press pulse.
  - Latency from a stable raw press to the press pulse: 2 + DEBOUNCE_CYCLES cycles, ±1.
- FSM states: PAUSE, RUN.
  - PAUSE + run press -> RUN. Divider is cleared, so the first advance comes RUN_DIV cycles later.
  - PAUSE + step press -> one advance; stay in PAUSE.
  - PAUSE + step and run press in the same cycle -> run wins, step dropped.
  - RUN + run press -> PAUSE; divider cleared; no advance in that cycle.
  - RUN + step press -> ignored.
  - RUN: divider counts 0..RUN_DIV-1; advance when it equals RUN_DIV-1, then wraps to 0.
- Advance cycle:
  - step_pulse=1 for exactly one cycle, driven from a register (glitch-free).
  - On the closing edge: if load_pc=1, pc <= a_reg[PC_W-1:0] (a_reg[15] ignored); else pc <= pc+1.
  - pc = 2^PC_W-1 with no jump wraps to 0.
  - load_pc and a_reg are sampled only on that edge.
- running = (FSM==RUN), registered.
- Reset mid-run or mid-debounce: all state clears immediately; no partial advance.

Optional Feature:
BREAKPOINT_EN
- Defined:
  - In RUN, if the post-advance pc equals bp_addr, the FSM enters PAUSE on the edge after the PC update, and bp_hit is set.
  - bp_hit clears on the next step or run press.
  - Single-stepping onto bp_addr in PAUSE does not set bp_hit.
  - A run press while sitting on bp_addr resumes normally; the first advance leaves the address before the breakpoint is rechecked.
- Not defined: bp_addr is ignored, bp_hit is constant 0, and port list is unchanged.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, RUN_DIV=8.
1. Reset, then step held 20 cycles with load_pc=0 -> exactly one step_pulse; pc 0->1.
2. Step button bouncing 0/1 every 2 cycles for 12 cycles, then stable high -> exactly one advance, after stable level + 4 cycles.
3. pc=5, load_pc=1, a_reg=16'h8123, step -> pc=15'h0123 (bit 15 dropped). Force pc=15'h7FFF, load_pc=0, step -> pc=0.
4. Run press, load_pc=0 -> step_pulse every 8 cycles; pc 0,1,2,3. Step press during RUN -> no extra pulse. Second run press -> running=0, pulses stop.
5. Run and step pressed in the same cycle in PAUSE -> running=1, no immediate advance. rst_n low for 1 cycle mid-RUN -> pc=0, running=0 asynchronously.
6. With BREAKPOINT_EN, bp_addr=3, run from pc=0 -> pc stops at 3, running=0, bp_hit=1. Step press -> bp_hit=0, pc=4.

Source files
------------

// File: rtl/hack_pc_sequencer_if.sv
// Bus bundle between the Hack PC sequencer and its surroundings (buttons,
// control decoder, ROM address, debug status).
interface hack_pc_sequencer_if #(
   parameter int PC_W = 15
);
   logic            btn_step;
   logic            btn_run;
   logic            load_pc;
   logic [15:0]     a_reg;
   logic [PC_W-1:0] bp_addr;
   logic [PC_W-1:0] pc;
   logic            step_pulse;
   logic            running;
   logic            bp_hit;

   modport master (
      input  btn_step, btn_run, load_pc, a_reg, bp_addr,
      output pc, step_pulse, running, bp_hit
   );

   modport slave (
      output btn_step, btn_run, load_pc, a_reg, bp_addr,
      input  pc, step_pulse, running, bp_hit
   );
endinterface

// File: rtl/hack_pc_sequencer.sv
// Hack program counter with debounced step / run-pause buttons and a free-running
// divider. Optional breakpoint support is enabled by defining BREAKPOINT_EN.
module hack_pc_sequencer #(
   parameter int PC_W            = 15,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int RUN_DIV         = 50000000
) (
   input logic                 clk,
   input logic                 rst_n,
   hack_pc_sequencer_if.master bus
);
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DIV_W = $clog2(RUN_DIV + 1);
   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

   typedef enum logic [0:0] {
      PAUSE = 1'b0,
      RUN   = 1'b1
   } state_t;

   // index 0 = step button, index 1 = run button
   logic [1:0]      raw_s;
   logic [1:0]      sync1_r;
   logic [1:0]      sync2_r;
   logic [1:0]      db_r;
   logic [1:0]      press_r;
   logic [DB_W-1:0] cnt_r [2];

   state_t           state_r;
   logic [DIV_W-1:0] div_r;
   logic [PC_W-1:0]  pc_r;
   logic             step_pulse_r;
   logic             running_r;
   logic             step_press_s;
   logic             run_press_s;

   assign raw_s        = {bus.btn_run, bus.btn_step};
   assign step_press_s = press_r[0];
   assign run_press_s  = press_r[1];

   // Two-flop synchronizers for the asynchronous buttons
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Debounce counters: the level is accepted only after it differs from the
   // debounced value for DEBOUNCE_CYCLES consecutive cycles; a rising accept is a press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_r     <= 2'b00;
         press_r  <= 2'b00;
         cnt_r[0] <= '0;
         cnt_r[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] == db_r[i]) begin
               cnt_r[i]   <= '0;
               press_r[i] <= 1'b0;
            end else if (cnt_r[i] == DB_MAX) begin
               cnt_r[i]   <= '0;
               db_r[i]    <= sync2_r[i];
               press_r[i] <= sync2_r[i];
            end else begin
               cnt_r[i]   <= cnt_r[i] + DB_W'(1);
               press_r[i] <= 1'b0;
            end
         end
      end
   end

`ifdef BREAKPOINT_EN
   logic bp_hit_r;
   logic bp_check_r;
   logic unused_s;

   assign unused_s   = bus.a_reg[15];
   assign bus.bp_hit = bp_hit_r;
`else
   logic unused_s;

   assign unused_s   = bus.a_reg[15] ^ (^bus.bp_addr);
   assign bus.bp_hit = 1'b0;
`endif

   // Run/pause FSM, divider, commit strobe and PC; the PC moves on the edge
   // that closes step_pulse, sampling load_pc/a_reg only there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= PAUSE;
         div_r        <= '0;
         pc_r         <= '0;
         step_pulse_r <= 1'b0;
         running_r    <= 1'b0;
`ifdef BREAKPOINT_EN
         bp_hit_r     <= 1'b0;
         bp_check_r   <= 1'b0;
`endif
      end else begin
         step_pulse_r <= 1'b0;
         if (step_pulse_r) begin
            pc_r <= bus.load_pc ? bus.a_reg[PC_W-1:0] : pc_r + PC_W'(1);
         end else begin
            pc_r <= pc_r;
         end
`ifdef BREAKPOINT_EN
         bp_check_r <= step_pulse_r && (state_r == RUN);
         if (run_press_s || step_press_s) begin
            bp_hit_r <= 1'b0;
         end else begin
            bp_hit_r <= bp_hit_r;
         end
`endif
         case (state_r)
            PAUSE: begin
               if (run_press_s) begin
                  state_r   <= RUN;
                  running_r <= 1'b1;
                  div_r     <= '0;
               end else if (step_press_s) begin
                  step_pulse_r <= 1'b1;
               end else begin
                  running_r <= 1'b0;
               end
            end
            RUN: begin
               if (run_press_s) begin
                  state_r   <= PAUSE;
                  running_r <= 1'b0;
                  div_r     <= '0;
`ifdef BREAKPOINT_EN
               end else if (bp_check_r && (pc_r == bus.bp_addr)) begin
                  state_r   <= PAUSE;
                  running_r <= 1'b0;
                  div_r     <= '0;
                  bp_hit_r  <= 1'b1;
`endif
               end else if (div_r == DIV_MAX) begin
                  div_r        <= '0;
                  step_pulse_r <= 1'b1;
               end else begin
                  div_r <= div_r + DIV_W'(1);
               end
            end
            default: begin
               state_r   <= PAUSE;
               running_r <= 1'b0;
               div_r     <= '0;
            end
         endcase
      end
   end

   assign bus.pc         = pc_r;
   assign bus.step_pulse = step_pulse_r;
   assign bus.running    = running_r;
endmodule

// File: tb/tb_hack_pc_sequencer.sv
// Directed bench for hack_pc_sequencer with DEBOUNCE_CYCLES=4, RUN_DIV=8.
module tb_hack_pc_sequencer;
   localparam int PC_W = 15;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   pulse_cnt;

   hack_pc_sequencer_if #(.PC_W(PC_W)) bus_if ();

   hack_pc_sequencer #(
      .PC_W(PC_W),
      .DEBOUNCE_CYCLES(4),
      .RUN_DIV(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial pulse_cnt = 0;
   always @(negedge clk) begin
      if (bus_if.step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // wait (bounded) for the next step_pulse, returning elapsed cycles
   task automatic wait_pulse(input int lim, output int n);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (bus_if.step_pulse !== 1'b1 && n < lim);
   endtask

   task automatic wait_running(input logic v, input int lim, input string tag);
      int n;
      n = 0;
      while (bus_if.running !== v && n < lim) begin
         cyc(1);
         n++;
      end
      chk(tag, 32'(bus_if.running), 32'(v));
   endtask

   task automatic do_step(input string tag);
      int n;
      bus_if.btn_step = 1'b1;
      wait_pulse(15, n);
      chk(tag, 32'(bus_if.step_pulse), 32'd1);
      cyc(2);
      bus_if.btn_step = 1'b0;
      cyc(10);
   endtask

   initial begin
      int n;
      int c0;
      logic [PC_W-1:0] pc_save;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus_if.btn_step = 1'b0;
      bus_if.btn_run  = 1'b0;
      bus_if.load_pc  = 1'b0;
      bus_if.a_reg    = 16'h0000;
      bus_if.bp_addr  = 15'd3;
      cyc(3);
      chk("rst_pc", 32'(bus_if.pc), 32'd0);
      chk("rst_step_pulse", 32'(bus_if.step_pulse), 32'd0);
      chk("rst_running", 32'(bus_if.running), 32'd0);
      chk("rst_bp_hit", 32'(bus_if.bp_hit), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // 1: held step gives one pulse after 2 + 4 (+1 register) cycles
      c0 = pulse_cnt;
      bus_if.btn_step = 1'b1;
      wait_pulse(15, n);
      chk("t1_latency_ok", 32'((n >= 6) && (n <= 8)), 32'd1);
      chk("t1_pc_during_pulse", 32'(bus_if.pc), 32'd0);
      cyc(1);
      chk("t1_pulse_width", 32'(bus_if.step_pulse), 32'd0);
      chk("t1_pc_after", 32'(bus_if.pc), 32'd1);
      cyc(18);
      bus_if.btn_step = 1'b0;
      cyc(10);
      chk("t1_pulse_count", 32'(pulse_cnt - c0), 32'd1);

      // 2: bounce every 2 cycles, then stable high
      c0 = pulse_cnt;
      for (int i = 0; i < 6; i++) begin
         bus_if.btn_step = (i % 2 == 0) ? 1'b1 : 1'b0;
         cyc(2);
      end
      chk("t2_no_pulse_bounce", 32'(pulse_cnt - c0), 32'd0);
      bus_if.btn_step = 1'b1;
      wait_pulse(15, n);
      chk("t2_latency_ok", 32'((n >= 6) && (n <= 8)), 32'd1);
      cyc(10);
      bus_if.btn_step = 1'b0;
      cyc(10);
      chk("t2_pulse_count", 32'(pulse_cnt - c0), 32'd1);
      chk("t2_pc", 32'(bus_if.pc), 32'd2);

      // 3: jumps, bit 15 dropped, wrap at top of address space
      bus_if.load_pc = 1'b1;
      bus_if.a_reg   = 16'h0005;
      do_step("t3_pulse_a");
      chk("t3_pc_5", 32'(bus_if.pc), 32'd5);
      bus_if.a_reg = 16'h8123;
      do_step("t3_pulse_b");
      chk("t3_pc_0123", 32'(bus_if.pc), 32'h0123);
      bus_if.a_reg = 16'hFFFF;
      do_step("t3_pulse_c");
      chk("t3_pc_7fff", 32'(bus_if.pc), 32'h7FFF);
      bus_if.load_pc = 1'b0;
      bus_if.a_reg   = 16'h1234;
      do_step("t3_pulse_d");
      chk("t3_pc_wrap", 32'(bus_if.pc), 32'd0);

      // 4: run mode, pulse every 8 cycles
      bus_if.btn_run = 1'b1;
      wait_running(1'b1, 15, "t4_running");
      bus_if.btn_run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_pulse(20, n);
         chk("t4_gap", 32'(n), 32'd8);
         chk("t4_pc_seq", 32'(bus_if.pc), 32'(k));
      end
      cyc(1);
      chk("t4_pc_3", 32'(bus_if.pc), 32'd3);
      c0 = pulse_cnt;
      bus_if.btn_step = 1'b1;
      cyc(16);
      chk("t4_step_ignored", 32'(pulse_cnt - c0), 32'd2);
      bus_if.btn_step = 1'b0;
      bus_if.btn_run  = 1'b1;
      wait_running(1'b0, 15, "t4_paused");
      bus_if.btn_run = 1'b0;
      pc_save = bus_if.pc;
      c0 = pulse_cnt;
      cyc(30);
      chk("t4_no_pulses", 32'(pulse_cnt - c0), 32'd0);
      chk("t4_pc_frozen", 32'(bus_if.pc), 32'(pc_save));

      // 5: run beats step in the same cycle; async reset mid-run
      c0 = pulse_cnt;
      bus_if.btn_run  = 1'b1;
      bus_if.btn_step = 1'b1;
      wait_running(1'b1, 15, "t5_running");
      cyc(3);
      chk("t5_no_advance", 32'(pulse_cnt - c0), 32'd0);
      chk("t5_pc_same", 32'(bus_if.pc), 32'(pc_save));
      bus_if.btn_run  = 1'b0;
      bus_if.btn_step = 1'b0;
      cyc(12);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_pc", 32'(bus_if.pc), 32'd0);
      chk("t5_rst_running", 32'(bus_if.running), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      c0 = pulse_cnt;
      cyc(20);
      chk("t5_post_rst_idle", 32'(pulse_cnt - c0), 32'd0);
      chk("t5_post_rst_pc", 32'(bus_if.pc), 32'd0);

      // 6: breakpoint at 3 while running from 0
      bus_if.btn_run = 1'b1;
      wait_running(1'b1, 15, "t6_running");
      bus_if.btn_run = 1'b0;
`ifdef BREAKPOINT_EN
      wait_running(1'b0, 60, "t6_bp_stop");
      chk("t6_bp_pc", 32'(bus_if.pc), 32'd3);
      chk("t6_bp_hit", 32'(bus_if.bp_hit), 32'd1);
      cyc(20);
      chk("t6_bp_pc_held", 32'(bus_if.pc), 32'd3);
      do_step("t6_step_pulse");
      chk("t6_bp_cleared", 32'(bus_if.bp_hit), 32'd0);
      chk("t6_pc_4", 32'(bus_if.pc), 32'd4);
`else
      cyc(40);
      chk("t6_still_running", 32'(bus_if.running), 32'd1);
      chk("t6_bp_hit_zero", 32'(bus_if.bp_hit), 32'd0);
      chk("t6_pc_past_bp", 32'(bus_if.pc > 15'd3), 32'd1);
      bus_if.btn_run = 1'b1;
      wait_running(1'b0, 15, "t6_paused");
      bus_if.btn_run = 1'b0;
      cyc(10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
